// File: rtl/jtag_ctrl_pkg.sv
// Shared state encoding and TMS sequences for the bus-side JTAG scan master.
// Preamble constants are LSB-first: bit 0 is driven on the first tck cycle.
package jtag_ctrl_pkg;
  typedef enum logic [2:0] {TAP_RST, IDLE, PRE, SHIFT, POST, RSP} state_e;

  localparam logic [2:0] DR_PRE      = 3'b001;
  localparam int         DR_PRE_LEN  = 3;
  localparam logic [3:0] IR_PRE      = 4'b0011;
  localparam int         IR_PRE_LEN  = 4;
  localparam int         TAP_RST_LEN = 6;
  localparam int         POST_LEN    = 2;
endpackage

// File: rtl/jtag_tck_gen.sv
// tck divider: TCK_HALF clk low then TCK_HALF clk high; parks low when disabled.
// rise_stb marks the last low clk (sample point), fall_stb the last high clk.
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = $clog2(2 * TCK_HALF);
  localparam logic [CW-1:0] LAST    = CW'(2 * TCK_HALF - 1);
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_HALF - 1);
  localparam logic [CW-1:0] HALF    = CW'(TCK_HALF);

  logic [CW-1:0] cnt, cnt_n;

  assign rise_stb = en && (cnt == RISE_AT);
  assign fall_stb = en && (cnt == LAST);

  always_comb begin
    cnt_n = '0;
    if (en && cnt != LAST) cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt_n;
      tck <= (cnt_n >= HALF);
    end
  end
endmodule

// File: rtl/jtag_scan_ctrl.sv
// Bus-side JTAG master: runs one IR/DR scan per command, tracking TAP state
// open-loop, and returns the captured tdo bits on a valid/ready channel.
module jtag_scan_ctrl
  import jtag_ctrl_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int TCK_HALF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               tap_reset_req,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst_n,
  input  logic               tdo,
  input  logic               tdo_en
);
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [3:0] DR_PRE4 = {1'b0, DR_PRE};

  state_e             state, state_n;
  logic [CNT_W-1:0]   bcnt, bcnt_n, last_idx;
  logic               is_ir_q, pre_ir, accept, tck_en, fall_stb, rise_stb;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic               tms_d, tdi_d;

  assign cmd_ready = (state == IDLE) && !tap_reset_req;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);
  assign pre_ir    = accept ? cmd_is_ir : is_ir_q;
  // trst_n gating keeps the first tck cycle after reset a full period long
  assign tck_en    = trst_n && (state == TAP_RST || state == PRE ||
                                state == SHIFT   || state == POST);

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    last_idx = '0;
    case (state)
      TAP_RST: last_idx = CNT_W'(TAP_RST_LEN - 1);
      PRE:     last_idx = is_ir_q ? CNT_W'(IR_PRE_LEN - 1) : CNT_W'(DR_PRE_LEN - 1);
      SHIFT:   last_idx = CNT_W'(len_q) - CNT_W'(1);
      POST:    last_idx = CNT_W'(POST_LEN - 1);
      default: last_idx = '0;
    endcase
  end

  // Timed states advance only at a tck fall, so each tck cycle sees one tms/tdi.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    case (state)
      IDLE: begin
        if (tap_reset_req)  state_n = TAP_RST;
        else if (cmd_valid) state_n = (cmd_len == '0) ? RSP : PRE;
      end
      RSP: if (rsp_ready) state_n = IDLE;
      default: begin
        if (fall_stb) begin
          if (bcnt == last_idx) begin
            bcnt_n = '0;
            case (state)
              TAP_RST: state_n = IDLE;
              PRE:     state_n = SHIFT;
              SHIFT:   state_n = POST;
              default: state_n = RSP;
            endcase
          end else begin
            bcnt_n = bcnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // tms/tdi for the tck cycle that starts on this edge, registered glitch-free.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_n)
      TAP_RST: tms_d = (bcnt_n != CNT_W'(TAP_RST_LEN - 1));
      PRE:     tms_d = pre_ir ? IR_PRE[bcnt_n[1:0]] : DR_PRE4[bcnt_n[1:0]];
      SHIFT: begin
        tms_d = (bcnt_n == CNT_W'(len_q) - CNT_W'(1));
        tdi_d = data_q[bcnt_n[IDX_W-1:0]];
      end
      POST:    tms_d = (bcnt_n == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TAP_RST;
      bcnt     <= '0;
      trst_n   <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      is_ir_q  <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      trst_n <= 1'b1;
      tms    <= tms_d;
      tdi    <= tdi_d;
      if (accept) begin
        is_ir_q  <= cmd_is_ir;
        len_q    <= (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        data_q   <= cmd_data;
        rsp_data <= '0;
        rsp_err  <= (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
      end else if (state == SHIFT && rise_stb) begin
        rsp_data[bcnt[IDX_W-1:0]] <= tdo & tdo_en;
        if (!tdo_en) rsp_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl against a behavioural TAP with an 8-bit IR
// (capture 8'h01) and a 16-bit boundary chain.
module tb_jtag_scan_ctrl;
  localparam int MAX_LEN = 16, LEN_W = 5, TCK_HALF = 2;

  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_is_ir = 0, tap_reset_req = 0, rsp_ready = 0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi, trst_n, tdo, tdo_en;
  logic [MAX_LEN-1:0] rsp_data;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  jtag_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TCK_HALF(TCK_HALF)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tap_reset_req(tap_reset_req), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .tck(tck), .tms(tms),
    .tdi(tdi), .trst_n(trst_n), .tdo(tdo), .tdo_en(tdo_en)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_e;
  tap_e        ts = TLR;
  logic [7:0]  sr_ir = 8'h00, ir_reg = 8'h01;
  logic [15:0] sr_dr = 16'h0, chain = 16'h1234;
  int          sh_cnt = 0;
  logic        kill3 = 0, tdo_q = 0;
  int          tck_cnt = 0;
  logic        tms_log [0:2047];
  logic        tdi_log [0:2047];

  function automatic tap_e nxt(input tap_e s, input logic m);
    case (s)
      TLR:    nxt = m ? TLR    : RTI;
      RTI:    nxt = m ? SEL_DR : RTI;
      SEL_DR: nxt = m ? SEL_IR : CAP_DR;
      CAP_DR: nxt = m ? EX1_DR : SH_DR;
      SH_DR:  nxt = m ? EX1_DR : SH_DR;
      EX1_DR: nxt = m ? UPD_DR : PAU_DR;
      PAU_DR: nxt = m ? EX2_DR : PAU_DR;
      EX2_DR: nxt = m ? UPD_DR : SH_DR;
      UPD_DR: nxt = m ? SEL_DR : RTI;
      SEL_IR: nxt = m ? TLR    : CAP_IR;
      CAP_IR: nxt = m ? EX1_IR : SH_IR;
      SH_IR:  nxt = m ? EX1_IR : SH_IR;
      EX1_IR: nxt = m ? UPD_IR : PAU_IR;
      PAU_IR: nxt = m ? EX2_IR : PAU_IR;
      EX2_IR: nxt = m ? UPD_IR : SH_IR;
      UPD_IR: nxt = m ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ts     <= TLR;
      ir_reg <= 8'h01;
    end else begin
      case (ts)
        TLR:    ir_reg <= 8'h01;
        CAP_IR: begin sr_ir <= 8'h01; sh_cnt <= 0; end
        SH_IR:  begin sr_ir <= {tdi, sr_ir[7:1]}; sh_cnt <= sh_cnt + 1; end
        UPD_IR: ir_reg <= sr_ir;
        CAP_DR: begin sr_dr <= chain; sh_cnt <= 0; end
        SH_DR:  begin sr_dr <= {tdi, sr_dr[15:1]}; sh_cnt <= sh_cnt + 1; end
        UPD_DR: chain <= sr_dr;
        default: ;
      endcase
      ts <= nxt(ts, tms);
    end
  end

  always @(negedge tck)
    tdo_q <= (ts == SH_IR) ? sr_ir[0] : (ts == SH_DR) ? sr_dr[0] : 1'b0;

  always @(posedge tck) begin
    if (tck_cnt < 2048) begin
      tms_log[tck_cnt] <= tms;
      tdi_log[tck_cnt] <= tdi;
    end
    tck_cnt <= tck_cnt + 1;
  end

  assign tdo    = tdo_q;
  assign tdo_en = (ts == SH_IR || ts == SH_DR) && !(kill3 && sh_cnt == 3);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic             is_ir;
    logic [LEN_W-1:0] len;
    logic [15:0]      data;
    logic             kill;
    int               hold;
    logic [15:0]      exp_data;
    logic             exp_err;
    int               exp_lat;
    int               exp_tcks;
    logic [15:0]      exp_chain;
    logic [7:0]       exp_ir;
    int               seq_n;
    logic [31:0]      exp_tms;
    logic [31:0]      exp_tdi;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input int i);
    vec_t v;
    int lat, base;
    logic [31:0] gt, gd;
    logic [15:0] held_d;
    logic held_e, bp_ok;
    v = vecs[i];
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
    cmd_valid = 1; cmd_is_ir = v.is_ir; cmd_len = v.len; cmd_data = v.data; kill3 = v.kill;
    base = tck_cnt;
    @(posedge clk); #1;
    cmd_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d_tck_low_at_rsp", i), tck, 0);
    chk($sformatf("v%0d_rsp_data", i), rsp_data, v.exp_data);
    chk($sformatf("v%0d_rsp_err", i), rsp_err, v.exp_err);
    chk($sformatf("v%0d_tck_count", i), tck_cnt - base, v.exp_tcks);
    chk($sformatf("v%0d_chain", i), chain, v.exp_chain);
    chk($sformatf("v%0d_ir", i), ir_reg, v.exp_ir);
    if (v.seq_n > 0) begin
      gt = '0; gd = '0;
      for (int j = 0; j < v.seq_n; j++) begin
        gt[j] = tms_log[base + j];
        gd[j] = tdi_log[base + j];
      end
      chk($sformatf("v%0d_tms_seq", i), gt, v.exp_tms);
      chk($sformatf("v%0d_tdi_seq", i), gd, v.exp_tdi);
    end
    held_d = rsp_data; held_e = rsp_err; bp_ok = 1;
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      if (rsp_data !== held_d || rsp_err !== held_e || rsp_valid !== 1'b1 ||
          cmd_ready !== 1'b0 || tck !== 1'b0 || tms !== 1'b0) bp_ok = 0;
    end
    if (v.hold > 0) chk($sformatf("v%0d_backpressure", i), bp_ok, 1);
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk($sformatf("v%0d_rsp_valid_drop", i), rsp_valid, 0);
    chk($sformatf("v%0d_cmd_ready_back", i), cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [31:0] gt;
    logic stale;

    //        ir  len    data      kill hold exp_data  err lat tcks chain     ir    n   tms        tdi
    vecs[0] = '{1'b1, 5'd8,  16'h0002, 1'b0, 0,  16'h0001, 1'b0, 56, 14, 16'h1234, 8'h02, 14, 32'h1803,  32'h20};
    vecs[1] = '{1'b0, 5'd16, 16'hA5C3, 1'b0, 10, 16'h1234, 1'b0, 84, 21, 16'hA5C3, 8'h02, 21, 32'hC0001, 32'h52E18};
    vecs[2] = '{1'b0, 5'd20, 16'h0F0F, 1'b0, 0,  16'hA5C3, 1'b1, 84, 21, 16'h0F0F, 8'h02, 21, 32'hC0001, 32'h7878};
    vecs[3] = '{1'b0, 5'd16, 16'h0000, 1'b1, 0,  16'h0F07, 1'b1, 84, 21, 16'h0000, 8'h02, 0,  32'h0,     32'h0};
    vecs[4] = '{1'b0, 5'd0,  16'hFFFF, 1'b0, 0,  16'h0000, 1'b1, 0,  0,  16'h0000, 8'h02, 0,  32'h0,     32'h0};
    vecs[5] = '{1'b0, 5'd4,  16'h0005, 1'b0, 0,  16'h0000, 1'b0, 36, 9,  16'h5000, 8'h02, 9,  32'hC1,    32'h28};
    vecs[6] = '{1'b0, 5'd16, 16'hFFFF, 1'b0, 0,  16'h5000, 1'b0, 84, 21, 16'hFFFF, 8'h02, 0,  32'h0,     32'h0};
    vecs[7] = '{1'b0, 5'd4,  16'h0000, 1'b0, 0,  16'h000F, 1'b0, 36, 9,  16'h0FFF, 8'h02, 0,  32'h0,     32'h0};
    vecs[8] = '{1'b1, 5'd8,  16'h00FF, 1'b0, 0,  16'h0001, 1'b0, 56, 14, 16'h0FFF, 8'hFF, 0,  32'h0,     32'h0};
    vecs[9] = '{1'b0, 5'd16, 16'h1357, 1'b0, 0,  16'h0FFF, 1'b0, 84, 21, 16'h1357, 8'h01, 0,  32'h0,     32'h0};

    // Reset state and TAP reset sequence
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_trst_n", trst_n, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 1);
    base = tck_cnt;
    rst_n = 1;
    @(posedge clk); #1;
    chk("rel_trst_n", trst_n, 1);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rel_seq_clks", n, 24);
    chk("rel_busy", busy, 0);
    chk("rel_tck_count", tck_cnt - base, 6);
    gt = '0;
    for (int j = 0; j < 6; j++) gt[j] = tms_log[base + j];
    chk("rel_tms_seq", gt, 32'h1F);
    chk("rel_tap_state", ts, RTI);

    for (int i = 0; i < 9; i++) run_vec(i);
    kill3 = 0;

    // TMS-driven TAP reset request
    @(negedge clk);
    tap_reset_req = 1;
    #1;
    chk("req_cmd_ready_low", cmd_ready, 0);
    base = tck_cnt;
    @(posedge clk); #1;
    chk("req_busy", busy, 1);
    tap_reset_req = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_seq_clks", n, 24);
    chk("req_tck_count", tck_cnt - base, 6);
    chk("req_tap_state", ts, RTI);
    chk("req_ir_reset", ir_reg, 8'h01);

    // Reset in the middle of a DR shift
    @(negedge clk);
    cmd_valid = 1; cmd_is_ir = 0; cmd_len = 5'd16; cmd_data = 16'hBEEF;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!(ts == SH_DR && sh_cnt == 5) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reached_bit5", n < 200, 1);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_tck", tck, 0);
    chk("mid_trst_n", trst_n, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    stale = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      if (rsp_valid) stale = 1;
      n++;
    end
    chk("mid_rel_seq_clks", n, 24);
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) stale = 1;
    end
    chk("mid_no_stale_rsp", stale, 0);
    chk("mid_chain_untouched", chain, 16'h0FFF);

    run_vec(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
